// File: rtl/hit_clip_player.sv
// Hit/miss detector with saturating score and a ROM clip sequencer that
// feeds the left audio channel at a divided sample rate.
module hit_clip_player #(
    parameter int unsigned ADDR_W    = 18,
    parameter int unsigned DATA_W    = 6,
    parameter int unsigned NUM_CLIPS = 4,
    localparam int unsigned CW       = (NUM_CLIPS > 1) ? $clog2(NUM_CLIPS) : 1,
    parameter logic [NUM_CLIPS*2*ADDR_W-1:0] CLIP_BOUNDS = {
        18'd0,     18'd16395,
        18'd16396, 18'd66982,
        18'd66983, 18'd83254,
        18'd83255, 18'd137138},
    parameter int unsigned DIV       = 1200,
    parameter int unsigned HIT_CLIP  = 0,
    parameter int unsigned SCORE_W   = 11
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic [2:0]          sensor_addr,
    input  logic [2:0]          target_addr,
    input  logic                play_req,
    input  logic [CW-1:0]       clip_sel,
    input  logic                loop_en,
    input  logic                stop,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [DATA_W-1:0]   rom_q,
    output logic [31:0]         audio_out,
    output logic                sample_valid,
    output logic                busy,
    output logic                hit_led,
    output logic                hit,
    output logic                miss,
    output logic [SCORE_W-1:0]  score
);

    localparam int unsigned DW = $clog2(DIV);

    typedef enum logic {IDLE, PLAY} state_t;

    logic [2:0] s_q, t_q, s_p;
    logic       match_c;

    assign match_c = (s_q == t_q) && (t_q != 3'd0);

    // Input capture, hit/miss edge detection and saturating score
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            s_q     <= '0;
            t_q     <= '0;
            s_p     <= '0;
            hit_led <= 1'b0;
            hit     <= 1'b0;
            miss    <= 1'b0;
            score   <= '0;
        end else begin
            s_q     <= sensor_addr;
            t_q     <= target_addr;
            s_p     <= s_q;
            hit_led <= match_c;
            hit     <= match_c && !hit_led;
            miss    <= (s_q != s_p) && (s_q != 3'd0) && (s_q != t_q) && (t_q != 3'd0);
            if (hit && (score != '1))
                score <= score + SCORE_W'(1);
            else if (miss && (score != '0))
                score <= score - SCORE_W'(1);
        end
    end

    // Clip table: clip 0 occupies the MSBs, each entry is {start, end}
    logic [ADDR_W-1:0] clip_start [NUM_CLIPS];
    logic [ADDR_W-1:0] clip_end   [NUM_CLIPS];

    for (genvar k = 0; k < NUM_CLIPS; k++) begin : g_clip
        assign clip_start[k] = CLIP_BOUNDS[(NUM_CLIPS-1-k)*2*ADDR_W + ADDR_W +: ADDR_W];
        assign clip_end[k]   = CLIP_BOUNDS[(NUM_CLIPS-1-k)*2*ADDR_W +: ADDR_W];
    end

    state_t            state_q, state_d;
    logic [DW-1:0]     div_q, div_d;
    logic [ADDR_W-1:0] addr_d, cs_q, cs_d, ce_q, ce_d;
    logic              loop_q, loop_d;
    logic [31:0]       audio_d;
    logic              sv_d;
    logic              start_c;
    logic [CW-1:0]     clip_c;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Start arbitration (stop > hit > play_req) and sample sequencing
    always_comb begin
        state_d = state_q;
        addr_d  = rom_addr;
        div_d   = div_q;
        cs_d    = cs_q;
        ce_d    = ce_q;
        loop_d  = loop_q;
        audio_d = audio_out;
        sv_d    = 1'b0;
        start_c = 1'b0;
        clip_c  = clip_sel;

        if (hit) begin
            start_c = 1'b1;
            clip_c  = CW'(HIT_CLIP);
        end else if (play_req && (32'(clip_sel) < NUM_CLIPS)) begin
            start_c = 1'b1;
        end

        if (stop) begin
            state_d = IDLE;
            addr_d  = '0;
            div_d   = '0;
            audio_d = '0;
        end else if (start_c) begin
            state_d = PLAY;
            addr_d  = clip_start[clip_c];
            cs_d    = clip_start[clip_c];
            ce_d    = clip_end[clip_c];
            div_d   = '0;
            loop_d  = loop_en;
        end else if (state_q == IDLE) begin
            addr_d  = '0;
            div_d   = '0;
            audio_d = '0;
        end else if (div_q == DW'(DIV - 1)) begin
            div_d   = '0;
            audio_d = {rom_q, {(32-DATA_W){1'b0}}};
            sv_d    = 1'b1;
            if (rom_addr == ce_q) begin
                if (loop_q) begin
                    addr_d = cs_q;
                end else begin
                    state_d = IDLE;
                    addr_d  = '0;
                end
            end else begin
                addr_d = rom_addr + ADDR_W'(1);
            end
        end else begin
            div_d = div_q + DW'(1);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            rom_addr     <= '0;
            div_q        <= '0;
            cs_q         <= '0;
            ce_q         <= '0;
            loop_q       <= 1'b0;
            audio_out    <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            rom_addr     <= addr_d;
            div_q        <= div_d;
            cs_q         <= cs_d;
            ce_q         <= ce_d;
            loop_q       <= loop_d;
            audio_out    <= audio_d;
            sample_valid <= sv_d;
            busy         <= (state_d == PLAY);
        end
    end

endmodule
